// File: rtl/wb_scoreboard_if.sv
// Bundle of issue, result and register-file write signals for wb_scoreboard.
interface wb_scoreboard_if #(
   parameter int XLEN = 32
);
   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic [4:0]      iss_rs1;
   logic [4:0]      iss_rs2;
   logic            iss_ready;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic [XLEN-1:0] rf_rs1_data;
   logic [XLEN-1:0] rf_rs2_data;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rd_we;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;

   modport slave (
      input  iss_valid, iss_rd, iss_rs1, iss_rs2,
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  rf_rs1_data, rf_rs2_data,
      output iss_ready, lsu_ready, rs1_data, rs2_data,
      output rd_we, rd_addr, rd_data
   );

   modport master (
      output iss_valid, iss_rd, iss_rs1, iss_rs2,
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output rf_rs1_data, rf_rs2_data,
      input  iss_ready, lsu_ready, rs1_data, rs2_data,
      input  rd_we, rd_addr, rd_data
   );
endinterface

// File: rtl/wb_scoreboard.sv
// Writeback arbiter and per-register busy scoreboard.
// ALU results win the single write port; LSU results wait in a small FIFO.
// The registered write is forwarded onto operand reads for the cycle the
// register file array has not yet absorbed it.
module wb_scoreboard #(
   parameter int XLEN           = 32,
   parameter int LSU_FIFO_DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   wb_scoreboard_if.slave bus
);
   localparam int AW = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [31:0]      r_busy;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [4:0]       r_fifo_rd   [LSU_FIFO_DEPTH];
   logic [XLEN-1:0]  r_fifo_data [LSU_FIFO_DEPTH];
   logic             r_rd_we;
   logic [4:0]       r_rd_addr;
   logic [XLEN-1:0]  r_rd_data;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_alu_wr;
   logic             w_wr_en;
   logic [4:0]       w_wr_addr;
   logic [XLEN-1:0]  w_wr_data;
   logic             w_iss_ready;
   logic             w_iss_fire;
   logic [31:0]      w_busy_nxt;

   // FIFO status comes only from registered state, so lsu_ready never depends on a pop.
   assign w_full   = (r_count == CW'(LSU_FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   // rd=0 LSU results complete the handshake but are never stored.
   assign w_push   = bus.lsu_valid && !w_full && (bus.lsu_rd != 5'd0);
   // An rd=0 ALU result is dropped and frees the port for the FIFO head.
   assign w_alu_wr = bus.alu_valid && (bus.alu_rd != 5'd0);
   assign w_pop    = !w_alu_wr && !w_empty;

   assign w_wr_en   = w_alu_wr || w_pop;
   assign w_wr_addr = w_alu_wr ? bus.alu_rd   : r_fifo_rd[r_rptr];
   assign w_wr_data = w_alu_wr ? bus.alu_data : r_fifo_data[r_rptr];

   // busy[0] is held at zero, so x0 operands never stall.
   assign w_iss_ready = !r_busy[bus.iss_rd] && !r_busy[bus.iss_rs1] && !r_busy[bus.iss_rs2];
   assign w_iss_fire  = bus.iss_valid && w_iss_ready;

   // Next busy vector: clear the register being written, then let a new issue set win.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_en) begin
         w_busy_nxt[w_wr_addr] = 1'b0;
      end
      if (w_iss_fire && (bus.iss_rd != 5'd0)) begin
         w_busy_nxt[bus.iss_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Scoreboard busy bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wptr]   <= bus.lsu_rd;
         r_fifo_data[r_wptr] <= bus.lsu_data;
      end
   end

   // Registered register-file write port; address/data hold while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_we   <= 1'b0;
         r_rd_addr <= 5'd0;
         r_rd_data <= '0;
      end else begin
         r_rd_we <= w_wr_en;
         if (w_wr_en) begin
            r_rd_addr <= w_wr_addr;
            r_rd_data <= w_wr_data;
         end
      end
   end

   assign bus.iss_ready = w_iss_ready;
   assign bus.lsu_ready = !w_full;
   assign bus.rd_we     = r_rd_we;
   assign bus.rd_addr   = r_rd_addr;
   assign bus.rd_data   = r_rd_data;

   // Operand bypass from the in-flight write; x0 always reads zero.
   assign bus.rs1_data = (bus.iss_rs1 == 5'd0) ? '0 :
                         (r_rd_we && (r_rd_addr == bus.iss_rs1)) ? r_rd_data : bus.rf_rs1_data;
   assign bus.rs2_data = (bus.iss_rs2 == 5'd0) ? '0 :
                         (r_rd_we && (r_rd_addr == bus.iss_rs2)) ? r_rd_data : bus.rf_rs2_data;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: reset, ALU forwarding, ALU/LSU ordering,
// LSU latency, ALU starvation of the FIFO, rd=0 handling, reset mid-operation.
module tb_wb_scoreboard;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   zero_wr = 0;

   always #5 clk = ~clk;

   wb_scoreboard_if #(.XLEN(32)) bus ();

   wb_scoreboard #(.XLEN(32), .LSU_FIFO_DEPTH(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   // Watch for any write to x0.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.rd_we === 1'b1 && bus.rd_addr === 5'd0) zero_wr++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.iss_valid   = 1'b0;
      bus.iss_rd      = 5'd0;
      bus.iss_rs1     = 5'd0;
      bus.iss_rs2     = 5'd0;
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = 5'd0;
      bus.alu_data    = 32'd0;
      bus.lsu_valid   = 1'b0;
      bus.lsu_rd      = 5'd0;
      bus.lsu_data    = 32'd0;
      bus.rf_rs1_data = 32'd0;
      bus.rf_rs2_data = 32'd0;
   endtask

   task automatic test_reset();
      int bad;
      idle();
      rst_n = 1'b0;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1234;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h5678;
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
      tick(); tick();
      checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we: got %b want 0", bus.rd_we); end
      checks++; if (bus.rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
      checks++; if (bus.rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_lsu_ready: got %b want 1", bus.lsu_ready); end
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %b want 1", bus.iss_ready); end
      idle();
      bad = 0;
      for (int r = 1; r < 32; r++) begin
         bus.iss_rs1 = 5'(r);
         #1;
         if (bus.iss_ready !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL reset_busy_clear: got %0d busy regs want 0", bad); end
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu_forward();
      idle();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL fwd_issue_ready: got %b want 1", bus.iss_ready); end
      tick();
      bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
      bus.iss_rs1 = 5'd5; bus.rf_rs1_data = 32'h12345678;
      bus.iss_rs2 = 5'd5; bus.rf_rs2_data = 32'h0000AAAA;
      #1;
      checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL fwd_raw_stall: got %b want 0", bus.iss_ready); end
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
      #1;
      checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL fwd_stall_alu_cycle: got %b want 0", bus.iss_ready); end
      checks++; if (bus.rs1_data !== 32'h12345678) begin errors++; $display("FAIL fwd_no_bypass: got %h want 12345678", bus.rs1_data); end
      tick();
      bus.alu_valid = 1'b0;
      #1;
      checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd5 || bus.rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_alu_write: got we=%b addr=%0d data=%h want 1/5/deadbeef", bus.rd_we, bus.rd_addr, bus.rd_data); end
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready_on_write: got %b want 1", bus.iss_ready); end
      checks++; if (bus.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_rs1: got %h want deadbeef", bus.rs1_data); end
      checks++; if (bus.rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_rs2: got %h want deadbeef", bus.rs2_data); end
      tick();
      checks++; if (bus.rd_we !== 1'b0 || bus.rd_addr !== 5'd5 || bus.rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_hold: got we=%b addr=%0d data=%h want 0/5/deadbeef", bus.rd_we, bus.rd_addr, bus.rd_data); end
      checks++; if (bus.rs1_data !== 32'h12345678) begin errors++; $display("FAIL fwd_after: got %h want 12345678", bus.rs1_data); end
   endtask

   task automatic test_alu_lsu_priority();
      idle();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
      tick();
      bus.iss_rd = 5'd4;
      tick();
      bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
      bus.iss_rs1 = 5'd3; bus.iss_rs2 = 5'd4;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h22;
      #1;
      checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b want 0", bus.iss_ready); end
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL prio_lsu_ready: got %b want 1", bus.lsu_ready); end
      tick();
      bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
      #1;
      checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd3 || bus.rd_data !== 32'h11) begin errors++; $display("FAIL prio_first: got we=%b addr=%0d data=%h want 1/3/11", bus.rd_we, bus.rd_addr, bus.rd_data); end
      bus.iss_rs1 = 5'd3; bus.iss_rs2 = 5'd0;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL prio_busy3_clear: got %b want 1", bus.iss_ready); end
      bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd4;
      #1;
      checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL prio_busy4_held: got %b want 0", bus.iss_ready); end
      tick();
      checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd4 || bus.rd_data !== 32'h22) begin errors++; $display("FAIL prio_second: got we=%b addr=%0d data=%h want 1/4/22", bus.rd_we, bus.rd_addr, bus.rd_data); end
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL prio_busy4_clear: got %b want 1", bus.iss_ready); end
      checks++; if (bus.rs2_data !== 32'h22) begin errors++; $display("FAIL prio_fwd_rs2: got %h want 22", bus.rs2_data); end
      tick();
      checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b want 0", bus.rd_we); end
   endtask

   task automatic test_lsu_latency();
      idle();
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h66;
      tick();
      bus.lsu_valid = 1'b0;
      checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL lsu_lat_t1: got %b want 0", bus.rd_we); end
      tick();
      checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd6 || bus.rd_data !== 32'h66) begin errors++; $display("FAIL lsu_lat_t2: got we=%b addr=%0d data=%h want 1/6/66", bus.rd_we, bus.rd_addr, bus.rd_data); end
      tick();
      checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL lsu_lat_t3: got %b want 0", bus.rd_we); end
   endtask

   task automatic test_back_to_back();
      int acc;
      logic exp_rdy;
      logic [31:0] exp_d;
      idle();
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA0 + 32'(i);
         bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(7 + acc); bus.lsu_data = 32'h70 + 32'(acc);
         exp_rdy = (acc < 2);
         #1;
         checks++; if (bus.lsu_ready !== exp_rdy) begin errors++; $display("FAIL b2b_lsu_ready[%0d]: got %b want %b", i, bus.lsu_ready, exp_rdy); end
         if (exp_rdy) acc++;
         tick();
         exp_d = 32'hA0 + 32'(i);
         checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd1 || bus.rd_data !== exp_d) begin errors++; $display("FAIL b2b_alu[%0d]: got we=%b addr=%0d data=%h want 1/1/%h", i, bus.rd_we, bus.rd_addr, bus.rd_data, exp_d); end
      end
      bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
      #1;
      checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", bus.lsu_ready); end
      tick();
      checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd7 || bus.rd_data !== 32'h70) begin errors++; $display("FAIL b2b_drain0: got we=%b addr=%0d data=%h want 1/7/70", bus.rd_we, bus.rd_addr, bus.rd_data); end
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL b2b_unfull: got %b want 1", bus.lsu_ready); end
      tick();
      checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd8 || bus.rd_data !== 32'h71) begin errors++; $display("FAIL b2b_drain1: got we=%b addr=%0d data=%h want 1/8/71", bus.rd_we, bus.rd_addr, bus.rd_data); end
      tick();
      checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", bus.rd_we); end
   endtask

   task automatic test_rd_zero();
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFFFFFF;
      #1;
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL zero_lsu_ready: got %b want 1", bus.lsu_ready); end
      tick();
      bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
      checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL zero_alu_drop: got %b want 0", bus.rd_we); end
      tick();
      checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL zero_lsu_drop: got %b want 0", bus.rd_we); end
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'hBB;
      tick();
      bus.lsu_valid = 1'b0;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF;
      tick();
      bus.alu_valid = 1'b0;
      checks++; if (bus.rd_we !== 1'b1 || bus.rd_addr !== 5'd11 || bus.rd_data !== 32'hBB) begin errors++; $display("FAIL zero_fifo_drain: got we=%b addr=%0d data=%h want 1/11/bb", bus.rd_we, bus.rd_addr, bus.rd_data); end
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
      tick();
      bus.iss_valid = 1'b0;
      bus.iss_rs1 = 5'd0; bus.rf_rs1_data = 32'h5555;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL zero_issue_noblock: got %b want 1", bus.iss_ready); end
      checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL zero_rs1_data: got %h want 0", bus.rs1_data); end
      tick();
      checks++; if (zero_wr != 0) begin errors++; $display("FAIL zero_never_written: got %0d writes want 0", zero_wr); end
   endtask

   task automatic test_reset_mid();
      int wr_after;
      idle();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd8;
      tick();
      bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'hC;
      tick();
      bus.lsu_rd = 5'd13; bus.lsu_data = 32'hD;
      tick();
      bus.lsu_valid = 1'b0;
      bus.iss_rs1 = 5'd8;
      #1;
      checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b want 0", bus.lsu_ready); end
      checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL mid_busy8: got %b want 0", bus.iss_ready); end
      bus.alu_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL mid_async: got %b want 0", bus.rd_we); end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      wr_after = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.rd_we !== 1'b0) wr_after++;
      end
      checks++; if (wr_after != 0) begin errors++; $display("FAIL mid_no_writes: got %0d writes want 0", wr_after); end
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL mid_busy8_clear: got %b want 1", bus.iss_ready); end
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL mid_lsu_ready: got %b want 1", bus.lsu_ready); end
   endtask

   initial begin
      test_reset();
      test_alu_forward();
      test_alu_lsu_priority();
      test_lsu_latency();
      test_back_to_back();
      test_rd_zero();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
